// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the default operand width.
package serial_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : serial_subtractor_pkg

// File: rtl/full_subtractor.sv
// One-bit full subtractor: X - Y - Bin, giving a difference bit and a borrow out.
module full_subtractor (
    input  logic X,
    input  logic Y,
    input  logic Bin,
    output logic Diff,
    output logic Bo
);

    logic x_xor_y;

    always_comb begin
        x_xor_y = X ^ Y;
        Diff    = x_xor_y ^ Bin;
        Bo      = (~X & Y) | (~x_xor_y & Bin);
    end

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell walks the operands
// LSB first over WIDTH cycles and presents D = A-B with its final borrow.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state_dbg
);

    // Handshake: start is accepted only on an edge where the FSM is in IDLE
    // (busy=0); A and B are captured on that same edge. done is a one-cycle
    // pulse, WIDTH edges after acceptance, during which D/Bout are new; they
    // then hold until the next done or reset. start while busy is dropped.

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t state, state_nxt;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_next;
    logic             borrow;
    logic [CNT_W-1:0] cnt;
    logic             diff_bit;
    logic             borrow_nxt;
    logic             last_step;

    full_subtractor u_fs (
        .X    (a_sr[0]),
        .Y    (b_sr[0]),
        .Bin  (borrow),
        .Diff (diff_bit),
        .Bo   (borrow_nxt)
    );

    always_comb begin
        last_step = (cnt == CNT_W'(WIDTH - 1));
        res_next  = {diff_bit, res_sr[WIDTH-1:1]};
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_RUN;
            ST_RUN:  if (last_step) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy      = (state == ST_RUN) || (state == ST_DONE);
        done      = (state == ST_DONE);
        state_dbg = state;
    end

    // Datapath: operand shifters, result shifter, borrow and step counter.
    // The final bit is folded into D on the last RUN edge so D is complete
    // in the same cycle done is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            D      <= '0;
            Bout   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_sr   <= A;
                        b_sr   <= B;
                        res_sr <= '0;
                        borrow <= 1'b0;
                        cnt    <= '0;
                    end
                end
                ST_RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_next;
                    borrow <= borrow_nxt;
                    cnt    <= cnt + CNT_W'(1);
                    if (last_step) begin
                        D    <= res_next;
                        Bout <= borrow_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed corner cases plus
// back-to-back random operands against an arithmetic reference model.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W-1:0] D;
    logic         Bout;
    logic         busy;
    logic         done;
    logic [1:0]   state_dbg;

    int n_tests;
    int n_fail;
    int done_cnt;

    logic [W:0] exp_q[$];

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .A         (A),
        .B         (B),
        .D         (D),
        .Bout      (Bout),
        .busy      (busy),
        .done      (done),
        .state_dbg (state_dbg)
    );

    // Clock and done-pulse monitor
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] wide;
        wide = {1'b0, a} - {1'b0, b};
        return wide;
    endfunction

    // Called #1 after a posedge with the DUT idle; returns #1 after the accept edge
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1;
        A     = a;
        B     = b;
        exp_q.push_back(ref_sub(a, b));
        @(posedge clk);
        #1;
        start = 1'b0;
        A     = W'($urandom);
        B     = W'($urandom);
    endtask

    // Wait for done; optionally inject a start (with junk operands) after glitch_at edges
    task automatic wait_done(input string tag, input int glitch_at);
        int         cycles;
        logic [W:0] exp;
        cycles = 0;
        while (!done && cycles < 40) begin
            if (cycles == glitch_at) begin
                start = 1'b1;
                A     = W'(1);
                B     = W'(1);
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            cycles++;
        end
        start = 1'b0;
        check({tag, "_latency"}, 64'(cycles), 64'(W));
        if (done && exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            check({tag, "_D"}, 64'(D), 64'(exp[W-1:0]));
            check({tag, "_Bout"}, 64'(Bout), 64'(exp[W]));
        end else begin
            check({tag, "_done_seen"}, 64'(done), 64'(1));
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
        @(posedge clk);
        #1;
        check({tag, "_done_drop"}, 64'(done), 64'(0));
        check({tag, "_idle"}, 64'(busy), 64'(0));
    endtask

    initial begin
        int         dc0;
        logic [W-1:0] hold_d;
        logic         hold_b;
        n_tests  = 0;
        n_fail   = 0;
        done_cnt = 0;
        rst      = 1'b1;
        start    = 1'b0;
        A        = '0;
        B        = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_D", 64'(D), 64'(0));
        check("rst_Bout", 64'(Bout), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_state", 64'(state_dbg), 64'(0));

        // Directed values
        start_op(W'(25), W'(10));
        check("run_busy", 64'(busy), 64'(1));
        wait_done("d25_10", -1);
        start_op(W'(10), W'(25));
        wait_done("d10_25", -1);
        start_op(W'(0), W'(1));
        wait_done("d0_1", -1);
        start_op(W'(8'hFF), W'(8'hFF));
        wait_done("dff_ff", -1);
        start_op(W'(8'h80), W'(0));
        wait_done("d80_0", -1);

        // Outputs hold while idle
        hold_d = D;
        hold_b = Bout;
        repeat (5) @(posedge clk);
        #1;
        check("hold_D", 64'(D), 64'(hold_d));
        check("hold_Bout", 64'(Bout), 64'(hold_b));
        check("hold_busy", 64'(busy), 64'(0));

        // start during RUN is ignored: exactly one done, original result
        dc0 = done_cnt;
        start_op(W'(25), W'(10));
        wait_done("ign", 2);
        repeat (4) @(posedge clk);
        #1;
        check("ign_one_done", 64'(done_cnt - dc0), 64'(1));
        check("ign_idle", 64'(busy), 64'(0));

        // Reset in RUN cycle 4 aborts without a done pulse
        dc0 = done_cnt;
        start_op(W'(200), W'(100));
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        void'(exp_q.pop_front());
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_D", 64'(D), 64'(0));
        check("abort_Bout", 64'(Bout), 64'(0));
        repeat (12) @(posedge clk);
        #1;
        check("abort_no_done", 64'(done_cnt - dc0), 64'(0));
        start_op(W'(200), W'(100));
        wait_done("after_abort", -1);

        // Back-to-back random operands
        for (int i = 0; i < 1000; i++) begin
            start_op(W'($urandom), W'($urandom));
            wait_done("rand", -1);
        end

        check("queue_empty", 64'(exp_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_serial_subtractor
